// File: rtl/toy_pack.sv
// Shared constants and types for the physical register free list.
//   PHY_REG_NUM       number of physical registers in the class
//   ARCH_ENTRY_NUM    architectural registers; phy 0..ARCH_ENTRY_NUM-1 form the reset mapping
//   RENAME_CHANNEL    allocation ports per cycle
//   freelist_state_e  NORMAL / RECOVER (one-cycle offer blackout after a flush)
package toy_pack;

    localparam int PHY_REG_NUM      = 64;
    localparam int ARCH_ENTRY_NUM   = 32;
    localparam int RENAME_CHANNEL   = 4;
    localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
    localparam int FREE_CNT_WIDTH   = $clog2(PHY_REG_NUM + 1);

    // Ids above the reset mapping start out free.
    localparam logic [PHY_REG_NUM-1:0] RESET_FREE_MAP =
        {{(PHY_REG_NUM - ARCH_ENTRY_NUM){1'b1}}, {ARCH_ENTRY_NUM{1'b0}}};

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } freelist_state_e;

    function automatic logic [FREE_CNT_WIDTH-1:0] popcount(input logic [PHY_REG_NUM-1:0] v);
        logic [FREE_CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < PHY_REG_NUM; i++) begin
            c = c + FREE_CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/toy_freelist_pick.sv
// Returns the NUM_PICK lowest set indices of a bitmap, lowest first.
// Cascaded find-first: each stage finds the lowest set bit of the bitmap
// left over by the previous stage, then masks it out for the next stage.
//   map_i  in   MAP_W              candidate bitmap
//   vld_o  out  NUM_PICK           pick k valid (compacted: fewer set bits -> upper picks 0)
//   id_o   out  NUM_PICK x ID_W    picked index per stage
module toy_freelist_pick #(
    parameter int MAP_W    = 64,
    parameter int NUM_PICK = 4,
    parameter int ID_W     = $clog2(MAP_W)
) (
    input  logic [MAP_W-1:0]                 map_i,
    output logic [NUM_PICK-1:0]              vld_o,
    output logic [NUM_PICK-1:0][ID_W-1:0]    id_o
);

    logic [MAP_W-1:0] rem;
    logic             found;

    always_comb begin
        rem   = map_i;
        vld_o = '0;
        id_o  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PICK; k++) begin
            found = 1'b0;
            for (int i = 0; i < MAP_W; i++) begin
                if (rem[i] && !found) begin
                    found    = 1'b1;
                    vld_o[k] = 1'b1;
                    id_o[k]  = ID_W'(i);
                end
            end
            if (found) begin
                rem[id_o[k]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/toy_phy_reg_freelist.sv
// Physical register free list for one register class.
// Offers up to RENAME_CHANNEL free phy ids per cycle to rename, absorbs the
// commit-side release / back-ref / release-comb bitmaps, and rebuilds the
// free set from the committed mapping on flush.
// Optional feature: define TOY_FREELIST_CHECK_EN to enable the sticky
// double-free detector and SVA checks; otherwise err_double_free_o is 0.
//   clk_i                 clock
//   rst_i                 synchronous reset, active-high (wins over flush and commit)
//   flush_i               pipeline flush
//   v_phy_release_i       commit: old mapping freed
//   v_phy_back_ref_i      commit: id became architecturally mapped
//   v_phy_release_comb_i  commit: id mapped and superseded in the same group
//   v_alloc_req_i         per-channel rename request (compacted)
//   v_alloc_vld_o         per-channel offer valid (compacted)
//   v_alloc_id_o          per-channel offered phy id
//   free_cnt_o            registered popcount of the free set
//   err_double_free_o     sticky double-free flag
module toy_phy_reg_freelist
    import toy_pack::*;
(
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             flush_i,
    input  logic [PHY_REG_NUM-1:0]                           v_phy_release_i,
    input  logic [PHY_REG_NUM-1:0]                           v_phy_back_ref_i,
    input  logic [PHY_REG_NUM-1:0]                           v_phy_release_comb_i,
    input  logic [RENAME_CHANNEL-1:0]                        v_alloc_req_i,
    output logic [RENAME_CHANNEL-1:0]                        v_alloc_vld_o,
    output logic [RENAME_CHANNEL-1:0][PHY_REG_ID_WIDTH-1:0]  v_alloc_id_o,
    output logic [FREE_CNT_WIDTH-1:0]                        free_cnt_o,
    output logic                                             err_double_free_o
);

    logic [PHY_REG_NUM-1:0]    free_q, free_d;
    logic [PHY_REG_NUM-1:0]    cmt_q, cmt_d;
    logic [PHY_REG_NUM-1:0]    taken;
    logic [FREE_CNT_WIDTH-1:0] cnt_q;
    freelist_state_e           state_q;
    logic [RENAME_CHANNEL-1:0] pick_vld;

    toy_freelist_pick #(
        .MAP_W    (PHY_REG_NUM),
        .NUM_PICK (RENAME_CHANNEL),
        .ID_W     (PHY_REG_ID_WIDTH)
    ) u_pick (
        .map_i (free_q),
        .vld_o (pick_vld),
        .id_o  (v_alloc_id_o)
    );

    // Offers are blanked while the free set is being rebuilt and while reset
    // is applied, so nothing can be handed out from stale state.
    assign v_alloc_vld_o = (state_q == NORMAL && !rst_i) ? pick_vld : '0;
    assign free_cnt_o    = cnt_q;

    // Ids handed out this cycle; a flush discards the handshakes.
    always_comb begin
        taken = '0;
        if (!flush_i) begin
            for (int ch = 0; ch < RENAME_CHANNEL; ch++) begin
                if (v_alloc_req_i[ch] && v_alloc_vld_o[ch]) begin
                    taken[v_alloc_id_o[ch]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmt_d = (cmt_q & ~v_phy_release_i) | (v_phy_back_ref_i & ~v_phy_release_comb_i);
        if (flush_i) begin
            // Everything not architecturally mapped after this commit is free.
            free_d = ~cmt_d;
        end else begin
            free_d = (free_q & ~taken) | v_phy_release_i | v_phy_release_comb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q  <= RESET_FREE_MAP;
            cmt_q   <= ~RESET_FREE_MAP;
            cnt_q   <= FREE_CNT_WIDTH'(PHY_REG_NUM - ARCH_ENTRY_NUM);
            state_q <= NORMAL;
        end else begin
            free_q <= free_d;
            cmt_q  <= cmt_d;
            cnt_q  <= popcount(free_d);
            case (state_q)
                NORMAL:  state_q <= flush_i ? RECOVER : NORMAL;
                RECOVER: state_q <= flush_i ? RECOVER : NORMAL;
                default: state_q <= NORMAL;
            endcase
        end
    end

`ifdef TOY_FREELIST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (|(((v_phy_release_i | v_phy_release_comb_i) & free_q) |
                       (v_phy_release_i & v_phy_release_comb_i))) begin
            err_q <= 1'b1;
        end
    end

    assign err_double_free_o = err_q;

    a_req_compact: assert property (@(posedge clk_i) disable iff (rst_i)
        ((v_alloc_req_i >> 1) & ~v_alloc_req_i) == '0);
    a_cnt_match: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q == popcount(free_q));
`else
    assign err_double_free_o = 1'b0;
`endif

endmodule

// File: tb/tb_toy_phy_reg_freelist.sv
module tb_toy_phy_reg_freelist;
    import toy_pack::*;

    localparam int N  = PHY_REG_NUM;
    localparam int RC = RENAME_CHANNEL;
    localparam int W  = PHY_REG_ID_WIDTH;
    localparam int CW = FREE_CNT_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst, flush;
    logic [N-1:0]          rel, bref, comb;
    logic [RC-1:0]         req, vld;
    logic [RC-1:0][W-1:0]  ids;
    logic [CW-1:0]         cnt;
    logic                  err;

    always #5 clk = ~clk;

    toy_phy_reg_freelist dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush),
        .v_phy_release_i      (rel),
        .v_phy_back_ref_i     (bref),
        .v_phy_release_comb_i (comb),
        .v_alloc_req_i        (req),
        .v_alloc_vld_o        (vld),
        .v_alloc_id_o         (ids),
        .free_cnt_o           (cnt),
        .err_double_free_o    (err)
    );

    // Reference model: plain sets as bit arrays.
    bit m_free[N];
    bit m_cmt[N];
    bit m_rec;
    bit m_err;
    int off_id[RC];
    bit off_v[RC];

    int checks   = 0;
    int failures = 0;

`ifdef TOY_FREELIST_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nfree();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_free[i]);
        return c;
    endfunction

    // The k-th offer is the k-th lowest free id; nothing while recovering or in reset.
    task automatic calc_offer();
        int k = 0;
        for (int c = 0; c < RC; c++) begin off_v[c] = 1'b0; off_id[c] = 0; end
        if (!m_rec && rst !== 1'b1) begin
            for (int i = 0; i < N; i++) begin
                if (m_free[i] && k < RC) begin
                    off_v[k] = 1'b1; off_id[k] = i; k++;
                end
            end
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; flush = 1'b0; rel = '0; bref = '0; comb = '0; req = '0;
    endtask

    // One clock: compare outputs with the model, advance the model on the edge.
    task automatic run_cycle();
        logic [RC-1:0] ev;
        bit            tk[N];
        bit            cn[N];
        #1;
        calc_offer();
        ev = '0;
        for (int c = 0; c < RC; c++) ev[c] = off_v[c];
        chk("vld", 64'(vld), 64'(ev));
        for (int c = 0; c < RC; c++) if (ev[c]) chk($sformatf("id%0d", c), 64'(ids[c]), 64'(off_id[c]));
        if (rst !== 1'b1) begin
            chk("free_cnt", 64'(cnt), 64'(nfree()));
            chk("err", 64'(err), 64'(m_err));
        end
        for (int i = 0; i < N; i++) tk[i] = 1'b0;
        if (!flush) for (int c = 0; c < RC; c++) if (req[c] && off_v[c]) tk[off_id[c]] = 1'b1;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_free[i] = (i >= ARCH_ENTRY_NUM);
                m_cmt[i]  = (i <  ARCH_ENTRY_NUM);
            end
            m_rec = 1'b0;
            m_err = 1'b0;
        end else begin
            if (CHECK_ON) begin
                for (int i = 0; i < N; i++)
                    if (((rel[i] || comb[i]) && m_free[i]) || (rel[i] && comb[i])) m_err = 1'b1;
            end
            for (int i = 0; i < N; i++) cn[i] = (m_cmt[i] && !rel[i]) || (bref[i] && !comb[i]);
            for (int i = 0; i < N; i++) begin
                if (flush) m_free[i] = !cn[i];
                else       m_free[i] = (m_free[i] && !tk[i]) || rel[i] || comb[i];
                m_cmt[i] = cn[i];
            end
            m_rec = flush;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_in(); rst = 1'b1;
        run_cycle();
        clr_in();
    endtask

    initial begin
        int  n, id;
        bit  tk[N];
        for (int i = 0; i < N; i++) begin m_free[i] = 1'b0; m_cmt[i] = 1'b0; end
        m_rec = 1'b0; m_err = 1'b0;

        // 1: reset then a full-width allocation
        clr_in(); rst = 1'b1;
        #1 chk("rst_vld", 64'(vld), 64'd0);
        run_cycle();
        clr_in(); req = 4'b1111;
        #1;
        chk("t1_vld", 64'(vld), 64'hF);
        chk("t1_cnt", 64'(cnt), 64'd32);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_id0", 64'(ids[0]), 64'd32);
        chk("t1_id3", 64'(ids[3]), 64'd35);
        run_cycle();
        chk("t1_cnt_next", 64'(cnt), 64'd28);
        chk("t1_id0_next", 64'(ids[0]), 64'd36);
        chk("t1_id3_next", 64'(ids[3]), 64'd39);

        // 2: drain to two free, then ask for four
        for (int c = 0; c < 6; c++) run_cycle();
        chk("t2_cnt4", 64'(cnt), 64'd4);
        req = 4'b0011;
        run_cycle();
        req = 4'b1111;
        #1;
        chk("t2_vld", 64'(vld), 64'h3);
        chk("t2_id0", 64'(ids[0]), 64'd62);
        chk("t2_id1", 64'(ids[1]), 64'd63);
        run_cycle();
        chk("t2_empty_cnt", 64'(cnt), 64'd0);
        chk("t2_empty_vld", 64'(vld), 64'd0);

        // 3: release while empty becomes offerable next cycle
        req = '0; rel[5] = 1'b1;
        run_cycle();
        clr_in();
        #1;
        chk("t3_cnt", 64'(cnt), 64'd1);
        chk("t3_vld", 64'(vld), 64'h1);
        chk("t3_id0", 64'(ids[0]), 64'd5);

        // 4: commit with back-ref / release / release-comb, then flush rebuild
        do_reset();
        req = 4'b0011;
        run_cycle();
        clr_in();
        bref[32] = 1'b1; bref[33] = 1'b1; rel[3] = 1'b1; comb[32] = 1'b1;
        run_cycle();
        clr_in();
        #1;
        chk("t4_cnt", 64'(cnt), 64'd32);
        chk("t4_id0", 64'(ids[0]), 64'd3);
        chk("t4_id1", 64'(ids[1]), 64'd32);
        chk("t4_id2", 64'(ids[2]), 64'd34);
        flush = 1'b1;
        run_cycle();
        clr_in();
        #1 chk("t4_recover_vld", 64'(vld), 64'd0);
        run_cycle();
        chk("t4_rebuilt_cnt", 64'(cnt), 64'd32);
        chk("t4_rebuilt_id0", 64'(ids[0]), 64'd3);
        chk("t4_rebuilt_id1", 64'(ids[1]), 64'd32);
        chk("t4_rebuilt_id2", 64'(ids[2]), 64'd34);

        // 5: uncommitted allocations are returned by flush
        do_reset();
        req = 4'b1111;
        run_cycle(); run_cycle();
        #1 chk("t5_id0", 64'(ids[0]), 64'd40);
        run_cycle();
        chk("t5_cnt_pre", 64'(cnt), 64'd20);
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        #1 chk("t5_recover_vld", 64'(vld), 64'd0);
        chk("t5_noflush_take", 64'(cnt), 64'd32);
        run_cycle();
        chk("t5_cnt", 64'(cnt), 64'd32);
        chk("t5_vld", 64'(vld), 64'hF);
        chk("t5_id0_after", 64'(ids[0]), 64'd32);
        req = '0; flush = 1'b1;
        run_cycle(); run_cycle();
        flush = 1'b0;
        #1 chk("t5_dbl_flush_vld", 64'(vld), 64'd0);
        run_cycle();
        chk("t5_dbl_flush_back", 64'(vld), 64'hF);

        // 6: double free detection (sticky until reset)
        do_reset();
        rel[50] = 1'b1;
        run_cycle();
        clr_in();
        #1 chk("t6_err", 64'(err), 64'(CHECK_ON));
        run_cycle(); run_cycle(); run_cycle();
        chk("t6_err_held", 64'(err), 64'(CHECK_ON));
        do_reset();
        chk("t6_err_clr", 64'(err), 64'd0);

        // Random traffic obeying the release protocol
        for (int cyc = 0; cyc < 600; cyc++) begin
            clr_in();
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 19) == 0);
            n     = $urandom_range(0, RC);
            for (int c = 0; c < RC; c++) req[c] = (c < n);
            calc_offer();
            for (int i = 0; i < N; i++) tk[i] = 1'b0;
            for (int c = 0; c < RC; c++) if (req[c] && off_v[c]) tk[off_id[c]] = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
                for (int t = 0; t < 16; t++) begin
                    id = $urandom_range(0, N - 1);
                    if (!m_free[id] && !tk[id]) begin rel[id] = 1'b1; break; end
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                for (int t = 0; t < 16; t++) begin
                    id = $urandom_range(0, N - 1);
                    if (!m_free[id] && !tk[id] && !rel[id]) begin comb[id] = 1'b1; break; end
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                for (int t = 0; t < 16; t++) begin
                    id = $urandom_range(0, N - 1);
                    if (!m_free[id] && !tk[id]) begin bref[id] = 1'b1; break; end
                end
            end
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
